// File: rtl/map_loader.sv
// rtl/map_loader.sv - picks a puzzle from the LFSR value and streams its 81 cells from ROM into the board memory
module map_loader #(
  parameter int NUM_MAPS   = 7,
  parameter int CELLS      = 81,
  parameter int ROM_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            random_number,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [3:0]            rom_data,
  output logic                  wr_en,
  output logic [6:0]            wr_addr,
  output logic [3:0]            wr_data,
  output logic                  wr_fixed,
  output logic [2:0]            map_index,
  output logic                  map_loaded,
  output logic                  busy,
  output logic                  load_error
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t     state, next_state;
  logic [6:0] cnt;
  logic [6:0] rd_cell;
  logic       rd_valid;
  logic [2:0] idx;
  logic       accept;
  logic       last_cell;
  logic       rom_bad;

  // LFSR never yields 0, but treat it as puzzle 0 rather than wrapping to 7
  always_comb begin
    idx = 3'd0;
    if (random_number != 3'd0) idx = random_number - 3'd1;
    if (idx >= 3'(NUM_MAPS)) idx = idx - 3'(NUM_MAPS);
  end

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_cell = (state == LOAD) && (cnt == 7'(CELLS - 1));
  assign rom_bad   = rd_valid && (rom_data > 4'd9);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    if (last_cell) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    if (start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 7'd0;
      rd_cell    <= 7'd0;
      rd_valid   <= 1'b0;
      map_index  <= 3'd0;
      map_loaded <= 1'b0;
      busy       <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state    <= next_state;
      rd_valid <= (state == LOAD);
      if (state == LOAD) begin
        cnt     <= cnt + 7'd1;
        rd_cell <= cnt;
      end
      if (rom_bad) load_error <= 1'b1;
      if (accept) begin
        map_index  <= idx;
        cnt        <= 7'd0;
        load_error <= 1'b0;
        map_loaded <= 1'b0;
        busy       <= 1'b1;
      end
      if (state == DRAIN) begin
        map_loaded <= 1'b1;
        busy       <= 1'b0;
      end
    end
  end

  assign rom_addr = (state == LOAD)
                  ? ROM_ADDR_W'(map_index) * ROM_ADDR_W'(CELLS) + ROM_ADDR_W'(cnt)
                  : '0;

  // ROM data lines up with rd_cell thanks to the one-cycle ROM latency
  assign wr_en    = rd_valid;
  assign wr_addr  = rd_cell;
  assign wr_data  = (rd_valid && rom_data <= 4'd9) ? rom_data : 4'd0;
  assign wr_fixed = (wr_data != 4'd0);

endmodule

// File: tb/tb_map_loader.sv
// tb/tb_map_loader.sv - scoreboard bench for map_loader with a registered ROM model
module tb_map_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] random_number;

  logic [9:0] rom_addr, rom_addr5;
  logic [3:0] rom_data, rom_data5;
  logic       wr_en, wr_en5;
  logic [6:0] wr_addr, wr_addr5;
  logic [3:0] wr_data, wr_data5;
  logic       wr_fixed, wr_fixed5;
  logic [2:0] map_index, map_index5;
  logic       map_loaded, map_loaded5;
  logic       busy, busy5;
  logic       load_error, load_error5;

  logic [3:0]  rom_mem [0:1023];
  logic [11:0] sb [$];
  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  map_loader #(.NUM_MAPS(7), .CELLS(81), .ROM_ADDR_W(10)) u_dut (
    .clk(clk), .reset(reset), .start(start), .random_number(random_number),
    .rom_addr(rom_addr), .rom_data(rom_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_fixed(wr_fixed), .map_index(map_index),
    .map_loaded(map_loaded), .busy(busy), .load_error(load_error)
  );

  map_loader #(.NUM_MAPS(5), .CELLS(81), .ROM_ADDR_W(10)) u_dut5 (
    .clk(clk), .reset(reset), .start(start), .random_number(random_number),
    .rom_addr(rom_addr5), .rom_data(rom_data5), .wr_en(wr_en5), .wr_addr(wr_addr5),
    .wr_data(wr_data5), .wr_fixed(wr_fixed5), .map_index(map_index5),
    .map_loaded(map_loaded5), .busy(busy5), .load_error(load_error5)
  );

  always @(posedge clk) begin
    rom_data  <= rom_mem[rom_addr];
    rom_data5 <= rom_mem[rom_addr5];
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      if (sb.size() == 0) begin
        check("unexpected_wr", 1, 0);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        check("wr_addr",  int'(wr_addr),  int'(e[11:5]));
        check("wr_data",  int'(wr_data),  int'(e[4:1]));
        check("wr_fixed", int'(wr_fixed), int'(e[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_map(input int idx);
    for (int i = 0; i < 81; i++) begin
      logic [3:0] v, d;
      v = rom_mem[idx * 81 + i];
      d = (v <= 4'd9) ? v : 4'd0;
      sb.push_back({7'(i), d, (d != 4'd0)});
    end
  endtask

  task automatic do_load(input logic [2:0] rn, input int idx, input int idx5,
                         input bit exp_err, input bit repulse);
    int n;
    push_map(idx);
    random_number = rn;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_map_index", int'(map_index), idx);
    check("start_busy", int'(busy), 1);
    check("start_loaded", int'(map_loaded), 0);
    check("start_err_clear", int'(load_error), 0);
    check("first_rom_addr", int'(rom_addr), idx * 81);
    check("map_index5", int'(map_index5), idx5);
    check("first_rom_addr5", int'(rom_addr5), idx5 * 81);
    n = 0;
    while (!map_loaded && n < 200) begin
      if (repulse && n == 29) begin
        start = 1'b1;
        random_number = 3'd6;
      end
      tick();
      start = 1'b0;
      n++;
      if (n == 80) check("last_rom_addr", int'(rom_addr), idx * 81 + 80);
      if (n == 81) begin
        check("drain_rom_addr", int'(rom_addr), 0);
        check("drain_busy", int'(busy), 1);
      end
    end
    check("load_cycles", n, 82);
    check("done_busy", int'(busy), 0);
    check("done_map_index", int'(map_index), idx);
    check("done_load_error", int'(load_error), int'(exp_err));
    check("sb_empty", sb.size(), 0);
    check("done_wr_en", int'(wr_en), 0);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) rom_mem[a] = 4'(a % 10);
    rom_mem[4 * 81 + 40] = 4'hC;
    reset = 1'b1;
    start = 1'b0;
    random_number = 3'd1;
    tick();
    tick();
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_wr_fixed", int'(wr_fixed), 0);
    check("rst_map_index", int'(map_index), 0);
    check("rst_loaded", int'(map_loaded), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(load_error), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    reset = 1'b0;
    tick();

    do_load(3'd3, 2, 2, 1'b0, 1'b0);
    do_load(3'd7, 6, 1, 1'b0, 1'b0);
    do_load(3'd0, 0, 0, 1'b0, 1'b0);
    do_load(3'd5, 4, 4, 1'b1, 1'b0);
    repeat (5) tick();
    check("err_sticky", int'(load_error), 1);
    check("done_hold", int'(map_loaded), 1);
    do_load(3'd2, 1, 1, 1'b0, 1'b1);

    // abort a load with reset after 50 cells have been written
    push_map(3);
    random_number = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    reset = 1'b1;
    tick();
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_loaded", int'(map_loaded), 0);
    check("abort_map_index", int'(map_index), 0);
    check("abort_rom_addr", int'(rom_addr), 0);
    check("abort_remaining", sb.size(), 31);
    sb.delete();
    reset = 1'b0;
    tick();
    check("idle_wr_en", int'(wr_en), 0);
    do_load(3'd1, 0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/map_loader.md
Name: map_loader

Overview:
- Downstream consumer of the 3-bit LFSR game-random stage.
- On a new-game request, samples the random value, selects one of NUM_MAPS stored puzzles, and streams its 81 cells from a synchronous puzzle ROM into the board memory write port.
- Asserts map_loaded when the board is populated. map_loaded low is what lets the LFSR keep stepping.

Parameters:
- NUM_MAPS, 7: number of puzzles in ROM. Legal range 4..7.
- CELLS, 81: cells per puzzle (9x9).
- ROM_ADDR_W, 10: ROM address width. Must satisfy NUM_MAPS*CELLS <= 2^ROM_ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  new-game request, level-sampled each cycle
- random_number  in  3  current LFSR value; legal values 1..7
- rom_addr  out  ROM_ADDR_W  puzzle ROM address
- rom_data  in  4  ROM cell value; 0 = empty, 1..9 = clue; registered ROM, 1-cycle read latency
- wr_en  out  1  board write strobe
- wr_addr  out  7  board cell index, 0..80
- wr_data  out  4  cell value written
- wr_fixed  out  1  cell is a given clue (wr_data != 0)
- map_index  out  3  latched puzzle number, 0..NUM_MAPS-1
- map_loaded  out  1  board fully loaded
- busy  out  1  load in progress
- load_error  out  1  sticky; ROM returned a value >9 during the current load

Behaviour:
- Reset (synchronous, reset high at an edge): state IDLE, rom_addr=0, wr_en=0, wr_addr=0, wr_data=0, wr_fixed=0, map_index=0, map_loaded=0, busy=0, load_error=0. Reset mid-load aborts immediately; no further writes occur.
- States:
  - IDLE: waits for start.
  - LOAD: issues 81 addresses.
  - DRAIN: final write.
  - DONE: map_loaded=1.
- Index mapping:
  - idx = random_number-1.
  - If idx >= NUM_MAPS, idx -= NUM_MAPS (single subtraction).
  - random_number=0 (illegal) maps to idx 0.
- Start accepted (edge k), from IDLE or DONE only:
  - map_index <= idx; internal counter cnt <= 0; load_error <= 0; map_loaded <= 0; state <= LOAD.
  - busy=1 from edge k until the DRAIN->DONE transition.
- During LOAD:
  - rom_addr = map_index*CELLS + cnt (combinational from registered map_index and cnt).
  - Each edge: cnt increments; a pipeline flag rd_valid <= 1; rd_cell <= cnt.
  - At the edge where cnt==80 is consumed, state <= DRAIN.
- Write port (combinational from the pipeline register and rom_data):
  - wr_en = rd_valid; wr_addr = rd_cell.
  - wr_data = rom_data if rom_data <= 9, else 0. A value >9 sets load_error at the next edge.
  - wr_fixed = (wr_data != 0).
- Timing:
  - Cell 0 is written in the cycle after edge k+1.
  - Cell 80 is written in the cycle after edge k+81.
  - Exactly 81 wr_en cycles, consecutive, with addresses 0..80 in order.
- DRAIN:
  - At edge k+82: rd_valid <= 0, state <= DONE, map_loaded <= 1.
  - map_loaded is first high 82 cycles after the start edge.
- DONE:
  - map_loaded holds 1; outputs are stable; wr_en=0.
  - A start here restarts the load with a freshly sampled random_number. map_loaded drops at that edge.
- start high during LOAD or DRAIN is ignored; no restart and no re-latch.
- start held high continuously: a reload is accepted at each DONE entry. This behaviour is intended.
- rom_addr = 0 outside LOAD.

Test Plan:
- Reset, then start pulse with random_number=3 -> map_index=2, 81 consecutive writes addr 0..80 with rom_addr 162..242, map_loaded=1 exactly 82 cycles after the start edge, busy=0 then.
- NUM_MAPS=5, random_number=7 -> idx 6 wraps to map_index=1, rom_addr starts at 81. random_number=0 forced -> map_index=0.
- ROM cell 40 of the map = 4'hC, others 0..9 -> wr_data=0 and wr_fixed=0 at wr_addr=40, load_error=1 sticky until the next start; clue cells give wr_fixed=1, zero cells give wr_fixed=0.
- start re-pulsed at cycle 30 of a load -> ignored; the write sequence and map_index are unchanged; map_loaded still rises at cycle 82.
- reset asserted at cycle 50 of a load -> next cycle wr_en=0, busy=0, map_loaded=0, map_index=0. A subsequent start performs a full 81-write load.
- From DONE, start with random_number=5 -> map_loaded falls the next cycle, map_index=4, reload completes 82 cycles later.
